spi_slave_regs: RTL and testbench

SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

---
 rtl/spi_slave_regs.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_slave_regs.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave with a small byte-wide register file.
// Commands: 03 read, 02 write (needs WEL), 05 read status, 06/04 set/clear WEL.
module spi_slave_regs #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck,
   input  logic              csn,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic              wr_stb,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      ADDR    = 3'd2,
      RD_DATA = 3'd3,
      WR_DATA = 3'd4,
      RDSR    = 3'd5,
      IGNORE  = 3'd6
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic              sck_meta_r;
   logic              sck_sync_r;
   logic              sck_prev_r;
   logic              csn_meta_r;
   logic              csn_sync_r;
   logic              mosi_meta_r;
   logic              mosi_sync_r;
   logic              armed_r;
   logic [2:0]        bit_cnt_r;
   logic [7:0]        rx_sh_r;
   logic [7:0]        tx_sh_r;
   logic [ADDR_W-1:0] addr_r;
   logic              wr_mode_r;
   logic              wel_r;
   logic              wel_pend_r;
   logic              wel_set_r;
   logic [7:0]        mem_r [DEPTH];

   logic              sck_rise_s;
   logic              sck_fall_s;
   logic              byte_done_s;
   logic              rd_state_s;
   logic [7:0]        rx_byte_s;
   logic [7:0]        rd_byte_s;

   // Edge detection and byte assembly on the synchronized SPI signals
   always_comb begin
      sck_rise_s  = sck_sync_r & ~sck_prev_r & ~csn_sync_r;
      sck_fall_s  = ~sck_sync_r & sck_prev_r & ~csn_sync_r;
      byte_done_s = sck_rise_s && (bit_cnt_r == 3'd7);
      rd_state_s  = (state_r == RD_DATA) || (state_r == RDSR);
      rx_byte_s   = {rx_sh_r[6:0], mosi_sync_r};
      if (state_r == RDSR) begin
         rd_byte_s = {6'b000000, wel_r, 1'b0};
      end else begin
         rd_byte_s = mem_r[addr_r];
      end
   end

   // Two-flop synchronizers; csn stages reset low so a transaction needs a fresh csn fall
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_meta_r  <= 1'b0;
         sck_sync_r  <= 1'b0;
         sck_prev_r  <= 1'b0;
         csn_meta_r  <= 1'b0;
         csn_sync_r  <= 1'b0;
         mosi_meta_r <= 1'b0;
         mosi_sync_r <= 1'b0;
      end else begin
         sck_meta_r  <= sck;
         sck_sync_r  <= sck_meta_r;
         sck_prev_r  <= sck_sync_r;
         csn_meta_r  <= csn;
         csn_sync_r  <= csn_meta_r;
         mosi_meta_r <= mosi;
         mosi_sync_r <= mosi_meta_r;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode: csn rise aborts from anywhere, byte boundaries advance the protocol
   always_comb begin
      state_next_s = state_r;
      if (state_r == IDLE) begin
         if (!csn_sync_r && armed_r) begin
            state_next_s = CMD;
         end else begin
            state_next_s = IDLE;
         end
      end else if (csn_sync_r) begin
         state_next_s = IDLE;
      end else if (byte_done_s) begin
         case (state_r)
            CMD: begin
               case (rx_byte_s)
                  8'h03:   state_next_s = ADDR;
                  8'h02:   state_next_s = wel_r ? ADDR : IGNORE;
                  8'h05:   state_next_s = RDSR;
                  default: state_next_s = IGNORE;
               endcase
            end
            ADDR:    state_next_s = wr_mode_r ? WR_DATA : RD_DATA;
            default: state_next_s = state_r;
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // Shift registers, address pointer, WEL, register file and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         armed_r    <= 1'b0;
         bit_cnt_r  <= 3'd0;
         rx_sh_r    <= 8'h00;
         tx_sh_r    <= 8'h00;
         addr_r     <= '0;
         wr_mode_r  <= 1'b0;
         wel_r      <= 1'b0;
         wel_pend_r <= 1'b0;
         wel_set_r  <= 1'b0;
         miso       <= 1'b0;
         miso_oe    <= 1'b0;
         wr_stb     <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 8'h00;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
      end else begin
         wr_stb <= 1'b0;

         if (csn_sync_r) begin
            armed_r <= 1'b1;
         end else if (state_r == IDLE && state_next_s == CMD) begin
            armed_r <= 1'b0;
         end

         if (state_r == IDLE || csn_sync_r) begin
            bit_cnt_r <= 3'd0;
         end else if (sck_rise_s && !rd_state_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            rx_sh_r   <= rx_byte_s;
         end else if (sck_fall_s && rd_state_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
         end

         if (byte_done_s && state_r == CMD) begin
            wr_mode_r  <= (rx_byte_s == 8'h02);
            wel_pend_r <= (rx_byte_s == 8'h06) || (rx_byte_s == 8'h04);
            wel_set_r  <= (rx_byte_s == 8'h06);
         end

         // A WEL command only takes effect if nothing follows its 8th bit
         if (sck_rise_s && state_r == IGNORE) begin
            wel_pend_r <= 1'b0;
         end

         if (byte_done_s && state_r == ADDR) begin
            addr_r <= rx_byte_s[ADDR_W-1:0];
         end

         if (byte_done_s && state_r == WR_DATA) begin
            mem_r[addr_r] <= rx_byte_s;
            wr_stb        <= 1'b1;
            wr_addr       <= addr_r;
            wr_data       <= rx_byte_s;
            addr_r        <= addr_r + ADDR_W'(1);
         end

         if (sck_fall_s && rd_state_s) begin
            if (bit_cnt_r == 3'd0) begin
               miso    <= rd_byte_s[7];
               tx_sh_r <= {rd_byte_s[6:0], 1'b0};
               if (state_r == RD_DATA) begin
                  addr_r <= addr_r + ADDR_W'(1);
               end
            end else begin
               miso    <= tx_sh_r[7];
               tx_sh_r <= {tx_sh_r[6:0], 1'b0};
            end
         end

         if (csn_sync_r && state_r != IDLE) begin
            if (state_r == WR_DATA) begin
               wel_r <= 1'b0;
            end else if (wel_pend_r) begin
               wel_r <= wel_set_r;
            end
            wel_pend_r <= 1'b0;
         end

         miso_oe <= (state_next_s == RD_DATA) || (state_next_s == RDSR);
         if (!((state_next_s == RD_DATA) || (state_next_s == RDSR))) begin
            miso <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: acts as an SPI mode-0 master at f_clk/16.
module tb_spi_slave_regs;

   localparam int HALF = 80;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sck = 1'b0;
   logic       csn = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic       miso_oe;
   logic       wr_stb;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;

   int         n_tests = 0;
   int         n_fail = 0;
   int         stb_n = 0;
   logic [3:0] stb_addr [8];
   logic [7:0] stb_data [8];
   logic       oe_seen = 1'b0;
   logic [7:0] rx;

   spi_slave_regs #(.ADDR_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .sck     (sck),
      .csn     (csn),
      .mosi    (mosi),
      .miso    (miso),
      .miso_oe (miso_oe),
      .wr_stb  (wr_stb),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   always #5 clk = ~clk;

   // Log every write strobe away from the active edge
   always @(negedge clk) begin
      if (wr_stb === 1'b1) begin
         if (stb_n < 8) begin
            stb_addr[stb_n] = wr_addr;
            stb_data[stb_n] = wr_data;
         end
         stb_n = stb_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bits(input logic [7:0] tx, input int n, output logic [7:0] rxb);
      rxb = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         mosi = tx[i];
         #HALF;
         rxb[i] = miso;
         if (miso_oe === 1'b1) oe_seen = 1'b1;
         sck = 1'b1;
         #HALF;
         sck = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rxb);
      bits(tx, 8, rxb);
   endtask

   task automatic start();
      csn = 1'b0;
      oe_seen = 1'b0;
      #HALF;
   endtask

   task automatic stop();
      #HALF;
      csn = 1'b1;
      #200;
   endtask

   task automatic rdsr(input string tag, input logic [7:0] exp);
      logic [7:0] r;
      start();
      xfer(8'h05, r);
      xfer(8'h00, r);
      stop();
      check(tag, r, exp);
   endtask

   task automatic one_byte_cmd(input logic [7:0] c);
      logic [7:0] r;
      start();
      xfer(c, r);
      stop();
   endtask

   initial begin
      repeat (5) @(posedge clk);
      #1;
      check("rst_miso", miso, 1'b0);
      check("rst_miso_oe", miso_oe, 1'b0);
      check("rst_wr_stb", wr_stb, 1'b0);
      check("rst_wr_addr", wr_addr, 4'h0);
      check("rst_wr_data", wr_data, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      #200;

      // Status register and WEL set/clear
      rdsr("rdsr_initial", 8'h00);
      one_byte_cmd(8'h06);
      rdsr("rdsr_after_wren", 8'h02);
      one_byte_cmd(8'h04);
      rdsr("rdsr_after_wrdi", 8'h00);

      // Write without WEL is ignored
      stb_n = 0;
      start(); xfer(8'h02, rx); xfer(8'h05, rx); xfer(8'hAB, rx); stop();
      check("nowel_stb_count", stb_n, 0);
      start(); xfer(8'h03, rx); xfer(8'h05, rx); xfer(8'h00, rx); stop();
      check("nowel_read_05", rx, 8'h00);

      // Burst write with address wrap, burst read, WEL auto-clear
      one_byte_cmd(8'h06);
      stb_n = 0;
      start(); xfer(8'h02, rx); xfer(8'h0E, rx);
      xfer(8'h11, rx); xfer(8'h22, rx); xfer(8'h33, rx); stop();
      check("burst_stb_count", stb_n, 3);
      check("burst_addr0", stb_addr[0], 4'hE);
      check("burst_addr1", stb_addr[1], 4'hF);
      check("burst_addr2", stb_addr[2], 4'h0);
      check("burst_data0", stb_data[0], 8'h11);
      check("burst_data1", stb_data[1], 8'h22);
      check("burst_data2", stb_data[2], 8'h33);
      start(); xfer(8'h03, rx); xfer(8'h0F, rx);
      xfer(8'h00, rx); check("read_0f", rx, 8'h22);
      xfer(8'h00, rx); check("read_00_wrap", rx, 8'h33);
      xfer(8'h00, rx); check("read_01", rx, 8'h00);
      check("read_oe_seen", oe_seen, 1'b1);
      stop();
      rdsr("rdsr_after_write", 8'h00);

      // Partial trailing byte is discarded
      one_byte_cmd(8'h06);
      stb_n = 0;
      start(); xfer(8'h02, rx); xfer(8'h03, rx); xfer(8'hC5, rx); bits(8'hFF, 5, rx); stop();
      check("partial_stb_count", stb_n, 1);
      check("partial_addr", stb_addr[0], 4'h3);
      check("partial_data", stb_data[0], 8'hC5);
      start(); xfer(8'h03, rx); xfer(8'h03, rx);
      xfer(8'h00, rx); check("partial_read_03", rx, 8'hC5);
      xfer(8'h00, rx); check("partial_read_04", rx, 8'h00);
      stop();

      // WREN cut short after 7 bits, and an unknown command
      start(); bits(8'h06, 7, rx); stop();
      rdsr("rdsr_wren_7bits", 8'h00);
      start(); xfer(8'h9F, rx); xfer(8'h00, rx); xfer(8'h00, rx); stop();
      check("unknown_cmd_oe", oe_seen, 1'b0);

      // Reset in the middle of a read data phase
      one_byte_cmd(8'h06);
      start(); xfer(8'h02, rx); xfer(8'h07, rx); xfer(8'h5A, rx); xfer(8'hA5, rx); stop();
      start(); xfer(8'h03, rx); xfer(8'h07, rx);
      xfer(8'h00, rx); check("prerst_read_07", rx, 8'h5A);
      bits(8'h00, 2, rx);
      #HALF;
      check("prerst_miso", miso, 1'b1);
      check("prerst_miso_oe", miso_oe, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_miso_oe", miso_oe, 1'b0);
      check("rst_mid_miso", miso, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      oe_seen = 1'b0;
      bits(8'h03, 8, rx);
      check("postrst_no_txn", oe_seen, 1'b0);
      stop();
      start(); xfer(8'h03, rx); xfer(8'h07, rx);
      xfer(8'h00, rx); check("postrst_read_07", rx, 8'h00);
      xfer(8'h00, rx); check("postrst_read_08", rx, 8'h00);
      stop();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
